// File: rtl/mp_adder_pkg.sv
// Shared definitions for the multi-precision adder sequencer: word width and FSM states.
package mp_adder_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mp_adder_seq_if.sv
// Operand/result handshake bundle for mp_adder_seq; master drives operands, slave returns the sum.
import mp_adder_pkg::*;

interface mp_adder_seq_if #(
    parameter int WORDS = 4
);
    localparam int W = WORD_W * WORDS;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] s;
    logic         co;
    logic         busy;

    modport master (
        output in_valid, a, b, ci, sub, out_ready,
        input  in_ready, out_valid, s, co, busy
    );

    modport slave (
        input  in_valid, a, b, ci, sub, out_ready,
        output in_ready, out_valid, s, co, busy
    );

endinterface

// File: rtl/full_adder_16b.sv
// Existing 16-bit full adder: s + co = a + b + ci.
module full_adder_16b (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        ci,
    output logic [15:0] s,
    output logic        co
);

    assign {co, s} = {1'b0, a} + {1'b0, b} + {16'b0, ci};

endmodule

// File: rtl/mp_adder_seq.sv
// WORDS*16-bit adder that reuses one full_adder_16b, one word per clock, LSW first.
// Build option: define MP_ADDER_SUB_EN to enable subtraction through the sub input.
import mp_adder_pkg::*;

module mp_adder_seq #(
    parameter int WORDS = 4
) (
    input  logic         clk,
    input  logic         rst,
    mp_adder_seq_if.slave bus
);

    localparam int W     = WORD_W * WORDS;
    localparam int CNT_W = $clog2(WORDS) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORDS - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic [W-1:0]       r_s;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_carry;
    logic               r_co;

    logic [W-1:0]       w_b_in;
    logic               w_ci_in;
    logic [W-1:0]       w_a_shift;
    logic [W-1:0]       w_b_shift;
    logic [W-1:0]       w_s_shift;
    logic [WORD_W-1:0]  w_sum;
    logic               w_co;
    logic               w_in_ready;
    logic               w_busy;
    logic               w_out_valid;

`ifdef MP_ADDER_SUB_EN
    // Two's-complement subtract: a + ~b + 1.
    assign w_b_in  = bus.sub ? ~bus.b : bus.b;
    assign w_ci_in = bus.ci | bus.sub;
`else
    assign w_b_in  = bus.b;
    assign w_ci_in = bus.ci;
`endif

    full_adder_16b u_adder (
        .a  (r_a[WORD_W-1:0]),
        .b  (r_b[WORD_W-1:0]),
        .ci (r_carry),
        .s  (w_sum),
        .co (w_co)
    );

    generate
        if (WORDS == 1) begin : g_single
            assign w_a_shift = '0;
            assign w_b_shift = '0;
            assign w_s_shift = w_sum;
        end else begin : g_multi
            assign w_a_shift = {{WORD_W{1'b0}}, r_a[W-1:WORD_W]};
            assign w_b_shift = {{WORD_W{1'b0}}, r_b[W-1:WORD_W]};
            assign w_s_shift = {w_sum, r_s[W-1:WORD_W]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = ST_IDLE;
        w_in_ready   = 1'b0;
        w_busy       = 1'b0;
        w_out_valid  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_in_ready   = 1'b1;
                w_state_next = bus.in_valid ? ST_RUN : ST_IDLE;
            end
            ST_RUN: begin
                w_busy       = 1'b1;
                w_state_next = (r_cnt == LAST_CNT) ? ST_DONE : ST_RUN;
            end
            ST_DONE: begin
                w_out_valid  = 1'b1;
                w_state_next = bus.out_ready ? ST_IDLE : ST_DONE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_s     <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_co    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_a     <= bus.a;
                        r_b     <= w_b_in;
                        r_carry <= w_ci_in;
                        r_cnt   <= '0;
                        r_s     <= '0;
                    end
                end
                ST_RUN: begin
                    r_s     <= w_s_shift;
                    r_a     <= w_a_shift;
                    r_b     <= w_b_shift;
                    r_carry <= w_co;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == LAST_CNT) begin
                        r_co <= w_co;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.busy      = w_busy;
    assign bus.out_valid = w_out_valid;
    assign bus.s         = r_s;
    assign bus.co        = r_co;

endmodule

// File: tb/tb_mp_adder_seq.sv
// Self-checking bench for mp_adder_seq: directed WORDS=4 cases plus random WORDS=1 traffic.
module tb_mp_adder_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    logic [63:0] exp4_s;
    logic        exp4_co;
    logic [63:0] exp1_s;
    logic        exp1_co;
    int          acc4 = 0;
    int          acc1 = 0;
    logic        prev4 = 1'b0;
    logic        prev1 = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mp_adder_seq_if #(.WORDS(4)) bus4 ();
    mp_adder_seq_if #(.WORDS(1)) bus1 ();

    mp_adder_seq #(.WORDS(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
    mp_adder_seq #(.WORDS(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain wide arithmetic on the whole operand.
    task automatic model(input logic [63:0] a, input logic [63:0] b, input logic ci,
                         input logic sub, input int words,
                         output logic [63:0] s, output logic co);
        logic [63:0] m;
        logic [63:0] bb;
        logic        cc;
        logic [64:0] sum;
        m  = (words == 4) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_0000_FFFF;
        bb = b;
        cc = ci;
`ifdef MP_ADDER_SUB_EN
        if (sub) begin
            bb = ~b;
            cc = 1'b1;
        end
`else
        if (sub) cc = ci;
`endif
        sum = {1'b0, a & m} + {1'b0, bb & m} + {64'b0, cc};
        co  = sum[16*words];
        s   = sum[63:0] & m;
    endtask

    // Per-cycle compare against the model for both instances.
    always @(negedge clk) begin
        chk("onehot4", 64'($countones({bus4.in_ready, bus4.busy, bus4.out_valid})), 64'd1);
        chk("onehot1", 64'($countones({bus1.in_ready, bus1.busy, bus1.out_valid})), 64'd1);
        if (bus4.out_valid) begin
            chk("s4", bus4.s, exp4_s);
            chk("co4", 64'(bus4.co), 64'(exp4_co));
            if (!prev4) chk("lat4", 64'(cyc - acc4), 64'd4);
        end
        if (bus1.out_valid) begin
            chk("s1", 64'(bus1.s), exp1_s);
            chk("co1", 64'(bus1.co), 64'(exp1_co));
            if (!prev1) chk("lat1", 64'(cyc - acc1), 64'd1);
        end
        prev4 <= bus4.out_valid;
        prev1 <= bus1.out_valid;
    end

    task automatic wait_ready4();
        int n;
        n = 0;
        while (!bus4.in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("in_ready4_wait", 64'(bus4.in_ready), 64'd1);
    endtask

    task automatic run4(input logic [63:0] a, input logic [63:0] b, input logic ci,
                        input logic sub, input int hold,
                        output logic [63:0] got_s, output logic got_co);
        int n;
        logic [63:0] held_s;
        wait_ready4();
        model(a, b, ci, sub, 4, exp4_s, exp4_co);
        bus4.a = a; bus4.b = b; bus4.ci = ci; bus4.sub = sub;
        bus4.in_valid = 1'b1;
        @(posedge clk); #1;
        acc4 = cyc;
        bus4.in_valid = 1'b0;
        bus4.a = 64'hDEAD_BEEF_0BAD_F00D;
        bus4.b = 64'h5555_AAAA_5555_AAAA;
        n = 0;
        while (!bus4.out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("done4_wait", 64'(bus4.out_valid), 64'd1);
        got_s  = bus4.s;
        got_co = bus4.co;
        held_s = bus4.s;
        for (int i = 0; i < hold; i++) begin
            bus4.in_valid = i[0];
            bus4.a = {$urandom, $urandom};
            chk("bp_in_ready", 64'(bus4.in_ready), 64'd0);
            chk("bp_s_stable", bus4.s, held_s);
            @(posedge clk); #1;
        end
        bus4.in_valid  = 1'b0;
        bus4.out_ready = 1'b1;
        @(posedge clk); #1;
        bus4.out_ready = 1'b0;
        chk("ov_drop4", 64'(bus4.out_valid), 64'd0);
        chk("in_ready_rise4", 64'(bus4.in_ready), 64'd1);
        $display("txn4 a=%h b=%h ci=%0d sub=%0d -> s=%h co=%0d", a, b, ci, sub, got_s, got_co);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] gs;
        logic        gc;
        bus4.in_valid = 1'b0; bus4.a = '0; bus4.b = '0; bus4.ci = 1'b0; bus4.sub = 1'b0;
        bus4.out_ready = 1'b0;
        bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.ci = 1'b0; bus1.sub = 1'b0;
        bus1.out_ready = 1'b1;
        exp4_s = '0; exp4_co = 1'b0; exp1_s = '0; exp1_co = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        chk("rst_in_ready", 64'(bus4.in_ready), 64'd1);
        chk("rst_out_valid", 64'(bus4.out_valid), 64'd0);
        chk("rst_busy", 64'(bus4.busy), 64'd0);
        chk("rst_s", bus4.s, 64'd0);
        chk("rst_co", 64'(bus4.co), 64'd0);

        run4(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, 0, gs, gc);
        chk("t1_s", gs, 64'h0000_0000_0001_0000);
        chk("t1_co", 64'(gc), 64'd0);

        run4(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 0, gs, gc);
        chk("t2_s", gs, 64'h0);
        chk("t2_co", 64'(gc), 64'd1);

        // Reset after two RUN edges, with co=1 left over from the last result
        wait_ready4();
        bus4.a = 64'h1111_2222_3333_4444; bus4.b = 64'h0101_0202_0303_0404;
        bus4.ci = 1'b0; bus4.sub = 1'b0; bus4.in_valid = 1'b1;
        @(posedge clk); #1;
        bus4.in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_busy", 64'(bus4.busy), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("t5_in_ready", 64'(bus4.in_ready), 64'd1);
        chk("t5_out_valid", 64'(bus4.out_valid), 64'd0);
        chk("t5_busy", 64'(bus4.busy), 64'd0);
        chk("t5_s", bus4.s, 64'd0);
        chk("t5_co", 64'(bus4.co), 64'd0);

        run4(64'h0001_0002_0003_0004, 64'h0010_0020_0030_0040, 1'b0, 1'b0, 0, gs, gc);
        chk("t5_new_s", gs, 64'h0011_0022_0033_0044);
        chk("t5_new_co", 64'(gc), 64'd0);

        run4(64'h5, 64'h7, 1'b0, 1'b1, 0, gs, gc);
`ifdef MP_ADDER_SUB_EN
        chk("t3a_s", gs, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("t3a_co", 64'(gc), 64'd0);
`else
        chk("t3a_s", gs, 64'd12);
        chk("t3a_co", 64'(gc), 64'd0);
`endif
        run4(64'h7, 64'h5, 1'b0, 1'b1, 0, gs, gc);
`ifdef MP_ADDER_SUB_EN
        chk("t3b_s", gs, 64'd2);
        chk("t3b_co", 64'(gc), 64'd1);
`else
        chk("t3b_s", gs, 64'd12);
        chk("t3b_co", 64'(gc), 64'd0);
`endif

        // Backpressure: 10 cycles in DONE with in_valid pulses
        run4(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0, 10, gs, gc);
        chk("t4_s", gs, 64'h2222_2222_2222_2212);
        chk("t4_co", 64'(gc), 64'd0);

        // WORDS=1 random traffic
        for (int k = 0; k < 10000; k++) begin
            logic [15:0] ra, rb;
            logic        rc, rs;
            ra = 16'($urandom); rb = 16'($urandom);
            rc = 1'($urandom); rs = 1'($urandom);
            if (!bus1.in_ready) chk("in_ready1", 64'(bus1.in_ready), 64'd1);
            model({48'b0, ra}, {48'b0, rb}, rc, rs, 1, exp1_s, exp1_co);
            bus1.a = ra; bus1.b = rb; bus1.ci = rc; bus1.sub = rs;
            bus1.in_valid = 1'b1;
            @(posedge clk); #1;
            acc1 = cyc;
            bus1.in_valid = 1'b0;
            @(posedge clk); #1;
            chk("ov1", 64'(bus1.out_valid), 64'd1);
            $display("txn1 a=%h b=%h ci=%0d sub=%0d -> s=%h co=%0d", ra, rb, rc, rs, bus1.s, bus1.co);
            @(posedge clk); #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
